sprite_ram_arbiter: RTL

//  Owns the single port of the sprite RAM (9 colour tiles x 576 px, 8-bit RGB332).

---
 rtl/sprite_ram_arbiter.sv | 80 ++++++++
 1 files changed

// File: rtl/sprite_ram_arbiter.sv
// sprite_ram_arbiter: owns the sprite RAM port; passes initializer writes through during fill,
// then arbitrates renderer reads (priority) against effects writes (starvation-guarded).
module sprite_ram_arbiter #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 8,
    parameter int RD_LATENCY = 1,
    parameter int MAX_WAIT   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init_busy_i,
    input  logic              init_we_i,
    input  logic [ADDR_W-1:0] init_addr_i,
    input  logic [DATA_W-1:0] init_data_i,
    input  logic              rd_req_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic              rd_gnt_o,
    output logic              rd_valid_o,
    output logic [DATA_W-1:0] rd_data_o,
    input  logic              wr_req_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic              wr_gnt_o,
    output logic              ready_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic              ram_we_o,
    input  logic [DATA_W-1:0] ram_rdata_i
);
    typedef enum logic {INIT, RUN} state_t;
    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic [7:0]        wait_cnt_q, wait_cnt_d;
    logic [RD_LATENCY:0] tok_q, tok_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              ram_we_q, ram_we_d;
    logic              run, force_wr, init;
    // Decisions use the registered state, so a request in the cycle init_busy rises may still win.
    assign run      = (state_q == RUN) && !rst;
    assign init     = (state_q == INIT);
    assign force_wr = wr_req_i && (wait_cnt_q == 8'(MAX_WAIT));
    assign rd_gnt_o = run && rd_req_i && !force_wr;
    assign wr_gnt_o = run && wr_req_i && (!rd_req_i || force_wr);
    assign rd_valid_o  = tok_q[RD_LATENCY];
    assign rd_data_o   = ram_rdata_i;
    assign ready_o     = ready_q;
    assign ram_addr_o  = ram_addr_q;
    assign ram_wdata_o = ram_wdata_q;
    assign ram_we_o    = ram_we_q;
    always_comb begin
        state_d     = init_busy_i ? INIT : RUN;
        ready_d     = !init_busy_i;
        tok_d       = {tok_q[RD_LATENCY-1:0], rd_gnt_o};
        wait_cnt_d  = (init || !wr_req_i || wr_gnt_o) ? 8'd0 :
                      (wait_cnt_q == 8'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + 8'd1;
        ram_addr_d  = init ? init_addr_i : rd_gnt_o ? rd_addr_i : wr_gnt_o ? wr_addr_i : ram_addr_q;
        ram_wdata_d = init ? init_data_i : wr_gnt_o ? wr_data_i : ram_wdata_q;
        ram_we_d    = init ? init_we_i : wr_gnt_o;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= INIT;
            ready_q     <= 1'b0;
            wait_cnt_q  <= '0;
            tok_q       <= '0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            ram_we_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            wait_cnt_q  <= wait_cnt_d;
            tok_q       <= tok_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            ram_we_q    <= ram_we_d;
        end
    end
endmodule
